// File: rtl/yadan_test_loader_pkg.sv
// -----------------------------------------------------------------------------
// yadan_test_loader_pkg
// Shared definitions for the SPI-slave debug loader: command codes, default
// frame bit counts, bit-counter width and the frame FSM state encoding.
// -----------------------------------------------------------------------------
package yadan_test_loader_pkg;

    // Command byte values (first byte of every frame)
    localparam logic [7:0] SPI_CMD_WR      = 8'h01;
    localparam logic [7:0] SPI_CMD_RD      = 8'h02;
    localparam logic [7:0] SPI_CMD_HOLD    = 8'h10;
    localparam logic [7:0] SPI_CMD_RELEASE = 8'h11;

    // Default frame geometry
    localparam int SPI_CMD_BITS      = 8;
    localparam int SPI_ADDR_BITS     = 32;
    localparam int SPI_DATA_BITS     = 32;
    localparam int SPI_WR_FRAME_BITS = SPI_CMD_BITS + SPI_ADDR_BITS + SPI_DATA_BITS;
    localparam int SPI_RD_HDR_BITS   = SPI_CMD_BITS + SPI_ADDR_BITS;

    // Bit counter width; large enough for any single field up to 255 bits
    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CMD    = 4'd1,
        ST_ADDR   = 4'd2,
        ST_WDATA  = 4'd3,
        ST_BUS_WR = 4'd4,
        ST_BUS_RD = 4'd5,
        ST_TURN   = 4'd6,
        ST_RDOUT  = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

endpackage

// File: rtl/yadan_spi_sync.sv
// -----------------------------------------------------------------------------
// yadan_spi_sync
// Two-flop synchronisers for the SPI test pins plus single-cycle edge strobes
// derived from the synchronised SCK and SCS.
//
// Ports:
//   clk, rst      system clock, async active-high reset
//   i_sck/i_scs/i_sdi   raw SPI pins
//   o_sck_rise    one-cycle strobe on synchronised SCK rising edge
//   o_sck_fall    one-cycle strobe on synchronised SCK falling edge
//   o_scs_fall    one-cycle strobe when synchronised SCS goes low
//   o_scs_rise    one-cycle strobe when synchronised SCS goes high
//   o_scs         synchronised SCS level
//   o_sdi         synchronised SDI, aligned with the SCK strobes
// -----------------------------------------------------------------------------
module yadan_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_scs,
    input  logic i_sdi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_scs_fall,
    output logic o_scs_rise,
    output logic o_scs,
    output logic o_sdi
);

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_scs_meta, r_scs_sync, r_scs_prev;
    logic r_sdi_meta, r_sdi_sync;

    // SCS resets high (deselected) so leaving reset never looks like a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_scs_meta <= 1'b1;
            r_scs_sync <= 1'b1;
            r_scs_prev <= 1'b1;
            r_sdi_meta <= 1'b0;
            r_sdi_sync <= 1'b0;
        end else begin
            r_sck_meta <= i_sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_scs_meta <= i_scs;
            r_scs_sync <= r_scs_meta;
            r_scs_prev <= r_scs_sync;
            r_sdi_meta <= i_sdi;
            r_sdi_sync <= r_sdi_meta;
        end
    end

    assign o_sck_rise = r_sck_sync & ~r_sck_prev;
    assign o_sck_fall = ~r_sck_sync & r_sck_prev;
    assign o_scs_fall = ~r_scs_sync & r_scs_prev;
    assign o_scs_rise = r_scs_sync & ~r_scs_prev;
    assign o_scs      = r_scs_sync;
    assign o_sdi      = r_sdi_sync;

endmodule

// File: rtl/yadan_test_loader.sv
// -----------------------------------------------------------------------------
// yadan_test_loader
// SPI-slave (mode 0) debug loader. Frames from the test port are turned into
// single 32-bit bus reads/writes on a memory-bus master port, and HOLD/RELEASE
// frames control the core reset hold.
//
// Ports:
//   clk, rst          system clock (>= 8x SCK), async active-high reset
//   test_sck/scs/sdi  SPI slave inputs, test_sdo SPI slave output
//   bus_req_o/we_o/addr_o/wdata_o   bus request, held until bus_ack_i
//   bus_rdata_i, bus_ack_i          read data / one-cycle completion
//   core_hold_o       1 keeps the core in reset
//   frame_err_o       one-cycle pulse on protocol error
//   busy_o            frame active or bus op pending
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for SCS to fall
// ST_CMD    | shifting in the command byte
// ST_ADDR   | shifting in the address
// ST_WDATA  | shifting in write data
// ST_BUS_WR | write request on the bus, waiting for ack
// ST_BUS_RD | read request on the bus, counting dummy falls meanwhile
// ST_TURN   | read data latched, finishing the dummy falls
// ST_RDOUT  | shifting read data out on SDO
// ST_DONE   | frame finished, ignore SCK until SCS is high
// ST_ERR    | raise frame_err_o once, then DONE
// -----------------------------------------------------------------------------
module yadan_test_loader
    import yadan_test_loader_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int CMD_W         = 8,
    parameter int TURN_BITS     = 8,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_sck,
    input  logic              test_scs,
    input  logic              test_sdi,
    output logic              test_sdo,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              core_hold_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    logic w_sck_rise, w_sck_fall, w_scs_fall, w_scs_rise, w_scs, w_sdi;

    yadan_spi_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (test_sck),
        .i_scs      (test_scs),
        .i_sdi      (test_sdi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_scs_fall (w_scs_fall),
        .o_scs_rise (w_scs_rise),
        .o_scs      (w_scs),
        .o_sdi      (w_sdi)
    );

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [SH_W-1:0]    r_shift, w_shift;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic [DATA_W-1:0]  r_wdata, w_wdata;
    logic               r_is_wr, w_is_wr;
    logic               r_req, w_req;
    logic               r_we, w_we;
    logic               r_hold, w_hold;
    logic               r_err, w_err;
    logic               r_sdo, w_sdo;

    logic [SH_W-1:0]    w_shift_in;
    logic [CMD_W-1:0]   w_cmd_in;

    // Shift register contents including the bit sampled on this rise
    assign w_shift_in = {r_shift[SH_W-2:0], w_sdi};
    assign w_cmd_in   = w_shift_in[CMD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_hold  <= HOLD_AT_RESET;
            r_err   <= 1'b0;
            r_sdo   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_is_wr <= w_is_wr;
            r_req   <= w_req;
            r_we    <= w_we;
            r_hold  <= w_hold;
            r_err   <= w_err;
            r_sdo   <= w_sdo;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_shift = r_shift;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_is_wr = r_is_wr;
        w_req   = r_req;
        w_we    = r_we;
        w_hold  = r_hold;
        w_err   = 1'b0;
        w_sdo   = 1'b0;

        // A started bus op always completes on ack, whatever the frame does;
        // an ack arriving after a late-read timeout is simply absorbed here.
        if (r_req && bus_ack_i) begin
            w_req = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_scs_fall && !r_req) begin
                    w_state = ST_CMD;
                    w_cnt   = '0;
                end
            end

            ST_CMD: begin
                if (w_scs_rise) begin
                    w_state = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_shift = w_shift_in;
                    if (r_cnt == CNT_W'(CMD_W - 1)) begin
                        w_cnt = '0;
                        if (w_cmd_in == CMD_W'(SPI_CMD_WR)) begin
                            w_is_wr = 1'b1;
                            w_state = ST_ADDR;
                        end else if (w_cmd_in == CMD_W'(SPI_CMD_RD)) begin
                            w_is_wr = 1'b0;
                            w_state = ST_ADDR;
                        end else if (w_cmd_in == CMD_W'(SPI_CMD_HOLD)) begin
                            w_hold  = 1'b1;
                            w_state = ST_DONE;
                        end else if (w_cmd_in == CMD_W'(SPI_CMD_RELEASE)) begin
                            w_hold  = 1'b0;
                            w_state = ST_DONE;
                        end else begin
                            w_state = ST_ERR;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ST_ADDR: begin
                if (w_scs_rise) begin
                    w_state = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_shift = w_shift_in;
                    if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                        w_cnt  = '0;
                        w_addr = w_shift_in[ADDR_W-1:0];
                        if (r_is_wr) begin
                            w_state = ST_WDATA;
                        end else begin
                            w_req   = 1'b1;
                            w_we    = 1'b0;
                            w_state = ST_BUS_RD;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ST_WDATA: begin
                if (w_scs_rise) begin
                    w_state = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_shift = w_shift_in;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_cnt   = '0;
                        w_wdata = w_shift_in[DATA_W-1:0];
                        w_req   = 1'b1;
                        w_we    = 1'b1;
                        w_state = ST_BUS_WR;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ST_BUS_WR: begin
                if (bus_ack_i) begin
                    w_state = ST_DONE;
                end
            end

            // Dummy falls are counted while the read is outstanding so the
            // turnaround window is fixed regardless of bus latency.
            ST_BUS_RD: begin
                if (w_sck_fall) begin
                    w_cnt = r_cnt + 1'b1;
                end
                if (bus_ack_i) begin
                    w_shift = SH_W'(bus_rdata_i);
                    w_state = w_scs ? ST_DONE : ST_TURN;
                end else if (!w_scs && (r_cnt >= CNT_W'(TURN_BITS))) begin
                    // Read data missed the turnaround: flag it and return zeros
                    w_err   = 1'b1;
                    w_shift = '0;
                    w_cnt   = '0;
                    w_state = ST_RDOUT;
                end
            end

            ST_TURN: begin
                if (w_scs_rise) begin
                    w_state = ST_IDLE;
                end else if (r_cnt >= CNT_W'(TURN_BITS)) begin
                    w_cnt   = '0;
                    w_state = ST_RDOUT;
                end else if (w_sck_fall) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            // Each fall presents the next MSB; the frame ends on the rise at
            // which the host samples the last bit, so SDO stays valid for it.
            ST_RDOUT: begin
                if (w_scs_rise) begin
                    w_state = ST_IDLE;
                end else begin
                    w_sdo = r_sdo;
                    if (w_sck_fall && (r_cnt < CNT_W'(DATA_W))) begin
                        w_sdo   = r_shift[DATA_W-1];
                        w_shift = {r_shift[SH_W-2:0], 1'b0};
                        w_cnt   = r_cnt + 1'b1;
                    end else if (w_sck_rise && (r_cnt == CNT_W'(DATA_W))) begin
                        w_cnt   = '0;
                        w_state = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (w_scs) begin
                    w_state = ST_IDLE;
                end
            end

            ST_ERR: begin
                w_err   = 1'b1;
                w_state = ST_DONE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign test_sdo    = r_sdo;
    assign bus_req_o   = r_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;
    assign core_hold_o = r_hold;
    assign frame_err_o = r_err;
    assign busy_o      = (r_state != ST_IDLE) | r_req;

endmodule

// File: tb/tb_yadan_test_loader.sv
// -----------------------------------------------------------------------------
// tb_yadan_test_loader
// Directed bench for the SPI debug loader: an SPI host drives frames, a bus
// slave model acks requests, and a monitor checks each bus request against a
// queue of expected transactions filled by the stimulus.
// -----------------------------------------------------------------------------
module tb_yadan_test_loader;

    localparam int HALF = 50;   // SCK half period in ns (clk period 10 ns)

    logic        clk, rst;
    logic        test_sck, test_scs, test_sdi, test_sdo;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        core_hold_o, frame_err_o, busy_o;

    yadan_test_loader #(
        .ADDR_W(32), .DATA_W(32), .CMD_W(8), .TURN_BITS(8), .HOLD_AT_RESET(1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .test_sck    (test_sck),
        .test_scs    (test_scs),
        .test_sdi    (test_sdi),
        .test_sdo    (test_sdo),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .core_hold_o (core_hold_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_rd_q[$];

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;

    int          ack_delay = 0;
    logic        slv_hold  = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus slave: acks each request ack_delay cycles after it is seen, unless held
    initial begin
        int  wait_n;
        logic active;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        active      = 1'b0;
        wait_n      = 0;
        forever begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (bus_req_o) begin
                if (!active) begin
                    active = 1'b1;
                    wait_n = 0;
                end
                if (!slv_hold && wait_n >= ack_delay) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = slv_rdata;
                    active      = 1'b0;
                end else begin
                    wait_n++;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Monitor: compares each new request with the expected queue and checks
    // that address/data/we stay stable for the whole request.
    initial begin
        logic prev_req, stab_bad;
        bus_t cur, e;
        prev_req = 1'b0;
        stab_bad = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_err_o === 1'b1) err_cnt++;
            if (bus_req_o && !prev_req) begin
                cur = '{bus_we_o, bus_addr_o, bus_wdata_o};
                stab_bad = 1'b0;
                if (exp_bus_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got addr 0x%08h we %0b, required no request",
                             bus_addr_o, bus_we_o);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_we", {31'b0, bus_we_o}, {31'b0, e.we});
                    chk("bus_addr", bus_addr_o, e.addr);
                    if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
                end
            end else if (bus_req_o) begin
                if (bus_we_o !== cur.we || bus_addr_o !== cur.addr || bus_wdata_o !== cur.wdata)
                    stab_bad = 1'b1;
            end else if (prev_req) begin
                chk("req_stable", {31'b0, stab_bad}, 32'h0);
            end
            prev_req = bus_req_o;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_start();
        @(negedge clk);
        test_scs = 1'b0;
        #(HALF);
    endtask

    task automatic spi_end();
        #(HALF);
        test_scs = 1'b1;
        #(4*HALF);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] rd);
        rd = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            test_sdi = val[i];
            #(HALF);
            test_sck = 1'b1;
            rd = {rd[30:0], test_sdo};
            #(HALF);
            test_sck = 1'b0;
        end
    endtask

    task automatic wr_frame(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        exp_bus_q.push_back('{1'b1, addr, data});
        spi_start();
        spi_bits(32'h01, 8, d);
        spi_bits(addr, 32, d);
        spi_bits(data, 32, d);
        spi_end();
    endtask

    task automatic rd_frame(input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        exp_bus_q.push_back('{1'b0, addr, 32'h0});
        exp_rd_q.push_back(exp);
        spi_start();
        spi_bits(32'h02, 8, d);
        spi_bits(addr, 32, d);
        spi_bits(32'h0, 8, d);
        spi_bits(32'h0, 32, d);
        spi_end();
        chk("rd_data", d, exp_rd_q.pop_front());
    endtask

    task automatic cmd_frame(input logic [7:0] cmd);
        logic [31:0] d;
        spi_start();
        spi_bits({24'h0, cmd}, 8, d);
        spi_end();
    endtask

    initial begin
        logic [31:0] d;
        int          e0;
        rst      = 1'b1;
        test_sck = 1'b0;
        test_scs = 1'b1;
        test_sdi = 1'b0;
        #22;
        chk("rst_sdo",   {31'b0, test_sdo},    32'h0);
        chk("rst_req",   {31'b0, bus_req_o},   32'h0);
        chk("rst_we",    {31'b0, bus_we_o},    32'h0);
        chk("rst_addr",  bus_addr_o,           32'h0);
        chk("rst_wdata", bus_wdata_o,          32'h0);
        chk("rst_err",   {31'b0, frame_err_o}, 32'h0);
        chk("rst_busy",  {31'b0, busy_o},      32'h0);
        chk("rst_hold",  {31'b0, core_hold_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Plain write, ack three cycles after the request
        ack_delay = 2;
        wr_frame(32'h0000_0010, 32'hCAFE_F00D);
        chk("wr_busy_after", {31'b0, busy_o}, 32'h0);

        // Read with a prompt ack
        ack_delay = 1;
        slv_rdata = 32'h1234_5678;
        e0 = err_cnt;
        rd_frame(32'h0000_0010, 32'h1234_5678);
        chk("rd_err_cnt", err_cnt - e0, 0);

        // Read whose ack arrives after the turnaround
        slv_hold  = 1'b1;
        slv_rdata = 32'hDEAD_BEEF;
        e0 = err_cnt;
        rd_frame(32'h0000_0020, 32'h0000_0000);
        chk("late_err_cnt", err_cnt - e0, 1);
        chk("late_busy_pending", {31'b0, busy_o}, 32'h1);
        slv_hold = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_busy_clear", {31'b0, busy_o}, 32'h0);
        ack_delay = 0;
        wr_frame(32'h0000_0024, 32'h0BAD_F00D);
        chk("late_wr_busy", {31'b0, busy_o}, 32'h0);

        // Frame aborted partway through the address
        e0 = err_cnt;
        spi_start();
        spi_bits(32'h01, 8, d);
        spi_bits(32'h0000_0ABC, 20, d);
        spi_end();
        chk("abort_busy", {31'b0, busy_o}, 32'h0);
        chk("abort_err_cnt", err_cnt - e0, 0);
        wr_frame(32'h0000_0030, 32'h55AA_33CC);
        chk("abort_wr_busy", {31'b0, busy_o}, 32'h0);

        // Unknown command byte
        e0 = err_cnt;
        spi_start();
        spi_bits(32'h55, 8, d);
        repeat (6) @(negedge clk);
        chk("badcmd_busy_in_frame", {31'b0, busy_o}, 32'h1);
        spi_bits(32'h0000_A5A5, 16, d);
        spi_end();
        chk("badcmd_err_cnt", err_cnt - e0, 1);
        chk("badcmd_busy_after", {31'b0, busy_o}, 32'h0);
        chk("badcmd_hold", {31'b0, core_hold_o}, 32'h0);

        // Core hold control
        cmd_frame(8'h10);
        chk("hold_set", {31'b0, core_hold_o}, 32'h1);
        cmd_frame(8'h11);
        chk("hold_release", {31'b0, core_hold_o}, 32'h0);

        // Reset while a write waits for its ack
        cmd_frame(8'h10);
        chk("hold_set2", {31'b0, core_hold_o}, 32'h1);
        slv_hold = 1'b1;
        wr_frame(32'h0000_0040, 32'h1357_9BDF);
        chk("pending_req", {31'b0, bus_req_o}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_req",  {31'b0, bus_req_o},   32'h0);
        chk("rst_mid_hold", {31'b0, core_hold_o}, 32'h0);
        chk("rst_mid_busy", {31'b0, busy_o},      32'h0);
        chk("rst_mid_addr", bus_addr_o,           32'h0);
        @(negedge clk);
        rst = 1'b0;
        slv_hold = 1'b0;
        repeat (4) @(negedge clk);

        // Recovery after reset
        wr_frame(32'h0000_0044, 32'h2468_ACE0);
        chk("final_busy", {31'b0, busy_o}, 32'h0);
        chk("exp_queue_empty", exp_bus_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
